// File: rtl/ip_header_parser.sv
// IPv4 receive header parser: validates the fixed 20-byte header, publishes its fields and forwards the payload bytes.
// Define IP_HEADER_PARSER_CHECKSUM_EN to build the header checksum check; without it the checksum is not examined.
module ip_header_parser (
    input  logic        clk,
    input  logic        areset,
    output logic        axis_i_tready,
    input  logic        axis_i_tvalid,
    input  logic        axis_i_tlast,
    input  logic [7:0]  axis_i_tdata,
    input  logic        axis_o_tready,
    output logic        axis_o_tvalid,
    output logic        axis_o_tlast,
    output logic [7:0]  axis_o_tdata,
    output logic [31:0] hdr_src_ip,
    output logic [31:0] hdr_dest_ip,
    output logic [7:0]  hdr_protocol,
    output logic [15:0] hdr_payload_length,
    output logic        hdr_valid,
    output logic        drop,
    output logic        truncated
);

    localparam logic [1:0]  ST_HEADER     = 2'd0;
    localparam logic [1:0]  ST_PAYLOAD    = 2'd1;
    localparam logic [1:0]  ST_TRIM       = 2'd2;
    localparam logic [4:0]  LAST_HDR_BYTE = 5'd19;
    localparam logic [15:0] HDR_LEN       = 16'd20;

    logic [1:0]  state;
    logic [4:0]  byte_cnt;
    logic [15:0] pay_cnt;
    logic [7:0]  prev_byte;
    logic [7:0]  sh_version;
    logic [15:0] sh_total_len;
    logic        sh_frag_ok;
    logic [7:0]  sh_protocol;
    logic [31:0] sh_src;
    logic [15:0] sh_dest_hi;

    logic        in_fire;
    logic        hdr_byte_fire;
    logic        hdr_last_byte;
    logic        hdr_pass;
    logic        csum_ok;
    logic [15:0] cur_word;
    logic [15:0] pay_len_calc;

    // Decode of the byte currently offered; cur_word pairs it with the preceding even byte.
    always_comb begin
        in_fire       = axis_i_tvalid & axis_i_tready;
        hdr_byte_fire = in_fire & (state == ST_HEADER);
        hdr_last_byte = (byte_cnt == LAST_HDR_BYTE);
        cur_word      = {prev_byte, axis_i_tdata};
        pay_len_calc  = sh_total_len - HDR_LEN;
        hdr_pass      = (sh_version == 8'h45) & (sh_total_len >= HDR_LEN) & sh_frag_ok & csum_ok;
    end

`ifdef IP_HEADER_PARSER_CHECKSUM_EN
    logic [15:0] csum;

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

    // Running ones'-complement sum of completed words; restarts on the first word of each header.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            csum <= 16'h0000;
        end else if (hdr_byte_fire && byte_cnt[0]) begin
            csum <= ones_add((byte_cnt == 5'd1) ? 16'h0000 : csum, cur_word);
        end
    end

    assign csum_ok = (ones_add(csum, cur_word) == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    // Stream handshakes: header and trim bytes are always taken, payload is a straight pass-through.
    always_comb begin
        axis_i_tready = 1'b0;
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = 1'b0;
        axis_o_tdata  = axis_i_tdata;
        if (areset) begin
            axis_i_tready = 1'b0;
        end else begin
            case (state)
                ST_HEADER: begin
                    axis_i_tready = 1'b1;
                end
                ST_PAYLOAD: begin
                    axis_i_tready = axis_o_tready;
                    axis_o_tvalid = axis_i_tvalid;
                    axis_o_tlast  = (pay_cnt == 16'd1) | axis_i_tlast;
                end
                ST_TRIM: begin
                    axis_i_tready = 1'b1;
                end
                default: begin
                    axis_i_tready = 1'b0;
                end
            endcase
        end
    end

    // Shadow copies of the header fields, filled as the header bytes go by.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            prev_byte    <= 8'h00;
            sh_version   <= 8'h00;
            sh_total_len <= 16'h0000;
            sh_frag_ok   <= 1'b0;
            sh_protocol  <= 8'h00;
            sh_src       <= 32'h0000_0000;
            sh_dest_hi   <= 16'h0000;
        end else if (hdr_byte_fire) begin
            prev_byte <= axis_i_tdata;
            case (byte_cnt)
                5'd0:    sh_version     <= axis_i_tdata;
                5'd3:    sh_total_len   <= cur_word;
                // prev_byte[5] is MF, prev_byte[4:0] the upper fragment-offset bits.
                5'd7:    sh_frag_ok     <= (prev_byte[5:0] == 6'd0) && (axis_i_tdata == 8'h00);
                5'd9:    sh_protocol    <= axis_i_tdata;
                5'd13:   sh_src[31:16]  <= cur_word;
                5'd15:   sh_src[15:0]   <= cur_word;
                5'd17:   sh_dest_hi     <= cur_word;
                default: sh_dest_hi     <= sh_dest_hi;
            endcase
        end
    end

    // Frame sequencing, published header fields and status pulses.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state              <= ST_HEADER;
            byte_cnt           <= 5'd0;
            pay_cnt            <= 16'd0;
            hdr_src_ip         <= 32'h0000_0000;
            hdr_dest_ip        <= 32'h0000_0000;
            hdr_protocol       <= 8'h00;
            hdr_payload_length <= 16'h0000;
            hdr_valid          <= 1'b0;
            drop               <= 1'b0;
            truncated          <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            drop      <= 1'b0;
            truncated <= 1'b0;
            case (state)
                ST_HEADER: begin
                    if (in_fire) begin
                        if (hdr_last_byte) begin
                            byte_cnt <= 5'd0;
                            if (hdr_pass) begin
                                hdr_src_ip         <= sh_src;
                                hdr_dest_ip        <= {sh_dest_hi, cur_word};
                                hdr_protocol       <= sh_protocol;
                                hdr_payload_length <= pay_len_calc;
                                hdr_valid          <= 1'b1;
                                pay_cnt            <= pay_len_calc;
                                if (axis_i_tlast) begin
                                    state <= ST_HEADER;
                                end else if (pay_len_calc != 16'd0) begin
                                    state <= ST_PAYLOAD;
                                end else begin
                                    state <= ST_TRIM;
                                end
                            end else begin
                                drop  <= 1'b1;
                                state <= axis_i_tlast ? ST_HEADER : ST_TRIM;
                            end
                        end else if (axis_i_tlast) begin
                            // Frame shorter than a header: discard and resynchronise on the next frame.
                            drop     <= 1'b1;
                            byte_cnt <= 5'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (in_fire) begin
                        pay_cnt <= pay_cnt - 16'd1;
                        if (axis_i_tlast) begin
                            state     <= ST_HEADER;
                            truncated <= (pay_cnt > 16'd1);
                        end else if (pay_cnt == 16'd1) begin
                            // Anything after the declared length is link-layer padding.
                            state <= ST_TRIM;
                        end
                    end
                end
                ST_TRIM: begin
                    if (in_fire && axis_i_tlast) begin
                        state <= ST_HEADER;
                    end
                end
                default: begin
                    state    <= ST_HEADER;
                    byte_cnt <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_header_parser.sv
// Self-checking bench for ip_header_parser: frames are checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_ip_header_parser;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b1;
    logic        axis_i_tready;
    logic        axis_o_tvalid;
    logic        axis_o_tlast;
    logic [7:0]  axis_o_tdata;
    logic [31:0] hdr_src_ip;
    logic [31:0] hdr_dest_ip;
    logic [7:0]  hdr_protocol;
    logic [15:0] hdr_payload_length;
    logic        hdr_valid;
    logic        drop;
    logic        truncated;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] pkt[$];
    logic [8:0] out_q[$];
    logic [8:0] exp_q[$];
    int hv_cnt, drop_cnt, trunc_cnt, stall_cnt;
    int exp_hv, exp_drop, exp_trunc;
    logic [31:0] exp_src, exp_dst;
    logic [7:0]  exp_proto;
    logic [15:0] exp_plen;

    ip_header_parser dut (
        .clk                (clk),
        .areset             (areset),
        .axis_i_tready      (axis_i_tready),
        .axis_i_tvalid      (in_valid),
        .axis_i_tlast       (in_last),
        .axis_i_tdata       (in_data),
        .axis_o_tready      (out_ready),
        .axis_o_tvalid      (axis_o_tvalid),
        .axis_o_tlast       (axis_o_tlast),
        .axis_o_tdata       (axis_o_tdata),
        .hdr_src_ip         (hdr_src_ip),
        .hdr_dest_ip        (hdr_dest_ip),
        .hdr_protocol       (hdr_protocol),
        .hdr_payload_length (hdr_payload_length),
        .hdr_valid          (hdr_valid),
        .drop               (drop),
        .truncated          (truncated)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge: payload beats, status pulses and header-phase stalls.
    always @(negedge clk) begin
        if (!areset) begin
            if (axis_o_tvalid && out_ready) out_q.push_back({axis_o_tlast, axis_o_tdata});
            if (hdr_valid) hv_cnt++;
            if (drop) drop_cnt++;
            if (truncated) trunc_cnt++;
            if (in_valid && !axis_i_tready) stall_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no $finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_sb();
        out_q.delete();
        exp_q.delete();
        hv_cnt = 0; drop_cnt = 0; trunc_cnt = 0; stall_cnt = 0;
        exp_hv = 0; exp_drop = 0; exp_trunc = 0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic fix_csum();
        logic [31:0] sum;
        logic [15:0] c;
        pkt[10] = 8'h00;
        pkt[11] = 8'h00;
        sum = 32'd0;
        for (int w = 0; w < 10; w++) sum = sum + {16'd0, pkt[2*w], pkt[2*w+1]};
        while (sum > 32'h0000FFFF) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        c = ~sum[15:0];
        pkt[10] = c[15:8];
        pkt[11] = c[7:0];
    endtask

    task automatic build_pkt(input int plen, input int frame_len, input logic [7:0] proto,
                             input logic [31:0] src, input logic [31:0] dst);
        logic [15:0] tl;
        logic [15:0] id;
        tl = 16'(plen + 20);
        id = 16'($urandom);
        pkt.delete();
        pkt.push_back(8'h45);    pkt.push_back(8'h00);   pkt.push_back(tl[15:8]); pkt.push_back(tl[7:0]);
        pkt.push_back(id[15:8]); pkt.push_back(id[7:0]); pkt.push_back(8'h40);    pkt.push_back(8'h00);
        pkt.push_back(8'h40);    pkt.push_back(proto);   pkt.push_back(8'h00);    pkt.push_back(8'h00);
        for (int k = 3; k >= 0; k--) pkt.push_back(src[8*k +: 8]);
        for (int k = 3; k >= 0; k--) pkt.push_back(dst[8*k +: 8]);
        fix_csum();
        while (pkt.size() < frame_len) pkt.push_back(8'($urandom));
    endtask

    task automatic build_spec_pkt(input int extra);
        logic [7:0] h [20];
        h = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
              8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
        pkt.delete();
        for (int k = 0; k < 20; k++) pkt.push_back(h[k]);
        for (int k = 0; k < 95 + extra; k++) pkt.push_back(8'($urandom));
    endtask

    // Reference: what one tlast-delimited frame pkt[lo..hi] must produce, from the header rules.
    task automatic model_range(input int lo, input int hi);
        int n, tl, pl, stop;
        logic [31:0] sum;
        logic [7:0] b6;
        logic ok;
        n = hi - lo + 1;
        if (n < 20) begin
            exp_drop++;
            return;
        end
        tl = int'({pkt[lo+2], pkt[lo+3]});
        b6 = pkt[lo+6];
        sum = 32'd0;
        for (int w = 0; w < 10; w++) sum = sum + {16'd0, pkt[lo+2*w], pkt[lo+2*w+1]};
        while (sum > 32'h0000FFFF) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        ok = (pkt[lo] == 8'h45) && (tl >= 20) && (b6[5] == 1'b0) && ({b6[4:0], pkt[lo+7]} == 13'd0);
`ifdef IP_HEADER_PARSER_CHECKSUM_EN
        ok = ok && (sum == 32'h0000FFFF);
`endif
        if (!ok) begin
            exp_drop++;
            return;
        end
        exp_hv++;
        exp_src   = {pkt[lo+12], pkt[lo+13], pkt[lo+14], pkt[lo+15]};
        exp_dst   = {pkt[lo+16], pkt[lo+17], pkt[lo+18], pkt[lo+19]};
        exp_proto = pkt[lo+9];
        pl        = tl - 20;
        exp_plen  = 16'(pl);
        if (n == 20) return;
        stop = (20 + pl < n) ? 20 + pl : n;
        for (int k = 20; k < stop; k++) exp_q.push_back({(k == stop - 1), pkt[lo+k]});
        if (n < 20 + pl) exp_trunc++;
    endtask

    task automatic send_range(input int lo, input int hi, input bit tail_last, input int gap_pct, input bit rnd_ready);
        int guard;
        bit done;
        for (int i = lo; i <= hi; i++) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                in_valid = 1'b0; in_last = 1'b0;
                out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = pkt[i]; in_last = tail_last && (i == hi);
            done = 1'b0; guard = 0;
            while (!done) begin
                out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
                @(negedge clk);
                done = axis_i_tready;
                @(posedge clk); #1;
                guard++;
                if (!done && guard > 200) begin
                    tests_run++; tests_failed++;
                    $display("FAIL send_timeout: byte %0d not accepted after %0d cycles, required acceptance", i, guard);
                    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
                    return;
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    endtask

    function automatic int stream_mismatch();
        if (out_q.size() != exp_q.size()) return (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        foreach (out_q[i]) if (out_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        areset = 1'b1; in_valid = 1'b1; in_data = 8'h45; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (axis_i_tready !== 1'b0) begin tests_failed++; $display("FAIL reset_tready: got %b, expected 0", axis_i_tready); end
        tests_run++;
        if (axis_o_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b, expected 0", axis_o_tvalid); end
        tests_run++;
        if ({hdr_valid, drop, truncated} !== 3'b000) begin tests_failed++; $display("FAIL reset_pulses: got %b, expected 000", {hdr_valid, drop, truncated}); end
        tests_run++;
        if ({hdr_src_ip, hdr_dest_ip, hdr_protocol, hdr_payload_length} !== 88'd0) begin
            tests_failed++; $display("FAIL reset_hdr: got %h %h %h %h, expected zeros", hdr_src_ip, hdr_dest_ip, hdr_protocol, hdr_payload_length);
        end
        @(posedge clk); #1;
        areset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (axis_i_tready !== 1'b1) begin tests_failed++; $display("FAIL idle_tready: got %b, expected 1", axis_i_tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_sb();
        build_spec_pkt(0);
        model_range(0, pkt.size() - 1);
        send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        settle();
        tests_run++;
        if (hv_cnt !== 1 || drop_cnt !== 0) begin tests_failed++; $display("FAIL basic_pulses: hdr_valid %0d drop %0d, expected 1 and 0", hv_cnt, drop_cnt); end
        tests_run++;
        if ({hdr_src_ip, hdr_dest_ip, hdr_protocol, hdr_payload_length} !== {32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95}) begin
            tests_failed++; $display("FAIL basic_hdr: got %h %h %h %0d, expected c0a80001 c0a800c7 11 95", hdr_src_ip, hdr_dest_ip, hdr_protocol, hdr_payload_length);
        end
        tests_run++;
        if (out_q.size() !== 95 || out_q[94] !== {1'b1, pkt[114]}) begin
            tests_failed++; $display("FAIL basic_count: got %0d beats, expected 95 with tlast on the last", out_q.size());
        end
        tests_run++;
        if (stream_mismatch() !== -1) begin tests_failed++; $display("FAIL basic_stream: first difference at beat %0d, got %0d beats, expected %0d", stream_mismatch(), out_q.size(), exp_q.size()); end
        tests_run++;
        if (stall_cnt !== 0) begin tests_failed++; $display("FAIL basic_bubbles: got %0d stalled cycles, expected 0", stall_cnt); end
    endtask

    task automatic test_padding();
        int first_len;
        clear_sb();
        build_spec_pkt(10);
        model_range(0, pkt.size() - 1);
        send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        first_len = out_q.size();
        build_pkt(17, 37, 8'h06, 32'h0A000001, 32'h0A000002);
        model_range(0, pkt.size() - 1);
        send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        settle();
        tests_run++;
        if (first_len !== 95) begin tests_failed++; $display("FAIL pad_count: got %0d beats from padded frame, expected 95", first_len); end
        tests_run++;
        if (hv_cnt !== 2 || drop_cnt !== 0) begin tests_failed++; $display("FAIL pad_pulses: hdr_valid %0d drop %0d, expected 2 and 0", hv_cnt, drop_cnt); end
        tests_run++;
        if (stream_mismatch() !== -1) begin tests_failed++; $display("FAIL pad_stream: first difference at beat %0d, got %0d beats, expected %0d", stream_mismatch(), out_q.size(), exp_q.size()); end
        tests_run++;
        if (hdr_dest_ip !== 32'h0A000002 || hdr_payload_length !== 16'd17) begin
            tests_failed++; $display("FAIL pad_next_hdr: got %h %0d, expected 0a000002 17", hdr_dest_ip, hdr_payload_length);
        end
        tests_run++;
        if (stall_cnt !== 0) begin tests_failed++; $display("FAIL pad_bubbles: got %0d stalled cycles, expected 0", stall_cnt); end
    endtask

    task automatic test_bad_checksum();
        clear_sb();
        build_pkt(5, 25, 8'h01, 32'h0B0B0B0B, 32'h0C0C0C0C);
        model_range(0, pkt.size() - 1);
        send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        build_spec_pkt(0);
        pkt[11] = 8'h62;
        model_range(0, pkt.size() - 1);
        send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        settle();
        tests_run++;
        if (hv_cnt !== exp_hv || drop_cnt !== exp_drop) begin
            tests_failed++; $display("FAIL csum_pulses: hdr_valid %0d drop %0d, expected %0d and %0d", hv_cnt, drop_cnt, exp_hv, exp_drop);
        end
        tests_run++;
        if (stream_mismatch() !== -1) begin tests_failed++; $display("FAIL csum_stream: first difference at beat %0d, got %0d beats, expected %0d", stream_mismatch(), out_q.size(), exp_q.size()); end
        tests_run++;
        if (hdr_src_ip !== exp_src || hdr_dest_ip !== exp_dst || hdr_protocol !== exp_proto || hdr_payload_length !== exp_plen) begin
            tests_failed++; $display("FAIL csum_hdr: got %h %h %h %0d, expected %h %h %h %0d", hdr_src_ip, hdr_dest_ip, hdr_protocol, hdr_payload_length, exp_src, exp_dst, exp_proto, exp_plen);
        end
    endtask

    task automatic test_bad_fields();
        clear_sb();
        build_pkt(12, 32, 8'h11, 32'h01020304, 32'h05060708);
        pkt[0] = 8'h46; fix_csum();
        model_range(0, pkt.size() - 1); send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        build_pkt(12, 32, 8'h11, 32'h01020304, 32'h05060708);
        pkt[6] = 8'h20; fix_csum();
        model_range(0, pkt.size() - 1); send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        build_pkt(0, 30, 8'h11, 32'h01020304, 32'h05060708);
        pkt[3] = 8'd19; fix_csum();
        model_range(0, pkt.size() - 1); send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        build_pkt(8, 28, 8'h11, 32'h01020304, 32'h05060708);
        model_range(0, 9); send_range(0, 9, 1'b1, 0, 1'b0);
        build_pkt(8, 28, 8'h2F, 32'h11223344, 32'h55667788);
        model_range(0, pkt.size() - 1); send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        settle();
        tests_run++;
        if (drop_cnt !== 4 || drop_cnt !== exp_drop) begin tests_failed++; $display("FAIL fields_drop: got %0d drops, expected 4", drop_cnt); end
        tests_run++;
        if (hv_cnt !== 1) begin tests_failed++; $display("FAIL fields_hv: got %0d hdr_valid, expected 1", hv_cnt); end
        tests_run++;
        if (stream_mismatch() !== -1 || out_q.size() !== 8) begin
            tests_failed++; $display("FAIL fields_stream: got %0d beats, expected 8 from the only good frame", out_q.size());
        end
        tests_run++;
        if (hdr_src_ip !== 32'h11223344 || hdr_protocol !== 8'h2F) begin tests_failed++; $display("FAIL fields_hdr: got %h %h, expected 11223344 2f", hdr_src_ip, hdr_protocol); end
    endtask

    task automatic test_truncated();
        clear_sb();
        build_pkt(95, 60, 8'h11, 32'hC0A80001, 32'hC0A800C7);
        model_range(0, pkt.size() - 1);
        send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        settle();
        tests_run++;
        if (trunc_cnt !== 1 || trunc_cnt !== exp_trunc) begin tests_failed++; $display("FAIL trunc_pulse: got %0d truncated pulses, expected 1", trunc_cnt); end
        tests_run++;
        if (out_q.size() !== 40 || out_q[39] !== {1'b1, pkt[59]}) begin tests_failed++; $display("FAIL trunc_count: got %0d beats, expected 40 with tlast on the last", out_q.size()); end
        tests_run++;
        if (stream_mismatch() !== -1) begin tests_failed++; $display("FAIL trunc_stream: first difference at beat %0d", stream_mismatch()); end
        tests_run++;
        if (hdr_payload_length !== 16'd95) begin tests_failed++; $display("FAIL trunc_plen: got %0d, expected 95", hdr_payload_length); end
    endtask

    task automatic test_reset_abort();
        int n;
        build_pkt(30, 50, 8'h11, 32'hAABBCCDD, 32'h01010101);
        n = pkt.size();
        send_range(0, 9, 1'b0, 0, 1'b0);
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (hdr_src_ip !== 32'd0 || hdr_payload_length !== 16'd0) begin tests_failed++; $display("FAIL abort_hdr_clear: got %h %0d, expected 0 0", hdr_src_ip, hdr_payload_length); end
        @(posedge clk); #1;
        clear_sb();
        exp_src = 32'd0; exp_dst = 32'd0; exp_proto = 8'd0; exp_plen = 16'd0;
        model_range(10, n - 1);
        send_range(10, n - 1, 1'b1, 0, 1'b0);
        build_pkt(6, 26, 8'h11, 32'h0D0D0D0D, 32'h0E0E0E0E);
        model_range(0, pkt.size() - 1);
        send_range(0, pkt.size() - 1, 1'b1, 0, 1'b0);
        settle();
        tests_run++;
        if (hv_cnt !== exp_hv || drop_cnt !== exp_drop) begin
            tests_failed++; $display("FAIL abort_pulses: hdr_valid %0d drop %0d, expected %0d and %0d", hv_cnt, drop_cnt, exp_hv, exp_drop);
        end
        tests_run++;
        if (stream_mismatch() !== -1) begin tests_failed++; $display("FAIL abort_stream: first difference at beat %0d, got %0d beats, expected %0d", stream_mismatch(), out_q.size(), exp_q.size()); end
        tests_run++;
        if (hdr_src_ip !== 32'h0D0D0D0D) begin tests_failed++; $display("FAIL abort_next_hdr: got %h, expected 0d0d0d0d", hdr_src_ip); end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        for (int p = 0; p < 100; p++) begin
            int plen, pad;
            plen = $urandom_range(40, 0);
            pad  = $urandom_range(3, 0);
            build_pkt(plen, 20 + plen + pad, 8'($urandom), $urandom, $urandom);
            model_range(0, pkt.size() - 1);
            send_range(0, pkt.size() - 1, 1'b1, 20, 1'b1);
        end
        settle();
        tests_run++;
        if (hv_cnt !== 100 || hv_cnt !== exp_hv) begin tests_failed++; $display("FAIL b2b_hv: got %0d hdr_valid, expected 100", hv_cnt); end
        tests_run++;
        if (drop_cnt !== 0 || trunc_cnt !== 0) begin tests_failed++; $display("FAIL b2b_status: drop %0d truncated %0d, expected 0 and 0", drop_cnt, trunc_cnt); end
        tests_run++;
        if (stream_mismatch() !== -1) begin tests_failed++; $display("FAIL b2b_stream: first difference at beat %0d, got %0d beats, expected %0d", stream_mismatch(), out_q.size(), exp_q.size()); end
        tests_run++;
        if (hdr_src_ip !== exp_src || hdr_dest_ip !== exp_dst || hdr_protocol !== exp_proto || hdr_payload_length !== exp_plen) begin
            tests_failed++; $display("FAIL b2b_hdr: got %h %h %h %0d, expected %h %h %h %0d", hdr_src_ip, hdr_dest_ip, hdr_protocol, hdr_payload_length, exp_src, exp_dst, exp_proto, exp_plen);
        end
    endtask

    initial begin
        clear_sb();
        exp_src = 32'd0; exp_dst = 32'd0; exp_proto = 8'd0; exp_plen = 16'd0;
        test_reset();
        test_basic();
        test_padding();
        test_bad_checksum();
        test_bad_fields();
        test_truncated();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ip_header_parser.md
# ip_header_parser

Receive-side counterpart of the IPv4 header generator. Consumes a byte-wide AXI stream carrying one IPv4 packet per tlast-delimited frame, such as the output of an Ethernet MAC/deframer. Parses and validates the fixed 20-byte header, presents the header fields on registered outputs, and forwards exactly the payload bytes on a byte-wide output stream. Packets failing any check are consumed and dropped without emitting any output beat.

## Interface
- No parameters; the stream is fixed at 1 byte wide, and header length is fixed at 20 bytes (IHL = 5).
- clk  in  1  system clock; all logic is on the rising edge
- areset  in  1  asynchronous reset, active-high
- axis_i_tready  out  1  input ready
- axis_i_tvalid  in  1  input valid
- axis_i_tlast  in  1  last byte of the received frame
- axis_i_tdata  in  8  frame byte, network order (MSB first)
- axis_o_tready  in  1  payload ready
- axis_o_tvalid  out  1  payload valid
- axis_o_tlast  out  1  last payload byte
- axis_o_tdata  out  8  payload byte
- hdr_src_ip  out  32  source address of the last accepted header
- hdr_dest_ip  out  32  destination address of the last accepted header
- hdr_protocol  out  8  protocol of the last accepted header
- hdr_payload_length  out  16  total_length − 20 of the last accepted header
- hdr_valid  out  1  one-cycle pulse when a header is accepted
- drop  out  1  one-cycle pulse when a packet is rejected
- truncated  out  1  one-cycle pulse when the frame ends before total_length

## Operation
- FSM states:
  - HEADER: counts bytes 0..19, captures fields, accumulates the checksum.
  - PAYLOAD: forwards bytes.
  - TRIM: discards trailing bytes up to the input tlast.
- HEADER state:
  - axis_i_tready = 1.
  - Fields are captured into shadow registers, not the hdr_* outputs.
  - The checksum is the ones'-complement sum of the 16-bit big-endian words formed from byte pairs (2n, 2n+1). Use a 17-bit add with end-around carry.
- Checks, all evaluated on the accept of byte 19, including the final word (bytes 18–19) combinationally:
  - byte0 == 8'h45
  - total_length ≥ 20
  - MF flag == 0 and fragment offset == 0
  - folded checksum == 16'hFFFF
- On pass:
  - Copy the shadow registers to the hdr_* outputs.
  - Pulse hdr_valid.
  - Next state is PAYLOAD if hdr_payload_length > 0; otherwise TRIM. If the tlast of byte 19 is set, next state is HEADER.
- On fail:
  - Pulse drop.
  - Next state is TRIM, or HEADER if the tlast of byte 19 is set.
  - hdr_* outputs keep their previous values.
- tlast on any header byte 0..18: pulse drop, clear the counter, stay in HEADER.
- PAYLOAD state:
  - Pure combinational pass-through: axis_o_tvalid = axis_i_tvalid, axis_i_tready = axis_o_tready, tdata passed unchanged.
  - A 16-bit down-counter is loaded with the payload length.
  - axis_o_tlast = (counter == 1) | axis_i_tlast.
  - On the last transfer:
    - If the counter reached 1 and the input tlast is clear, go to TRIM; this discards Ethernet padding.
    - If the input tlast is set, go to HEADER.
    - If the input tlast arrived with counter > 1, also pulse truncated.
- TRIM state: axis_i_tready = 1, axis_o_tvalid = 0. Return to HEADER on the accepted tlast.
- hdr_* outputs are stable from the hdr_valid pulse until the next hdr_valid.

## Timing
- Payload latency is 0 cycles, since PAYLOAD is combinational pass-through.
- hdr_valid and drop are registered and assert in the cycle after byte 19 is accepted. That is the same cycle the first payload byte can be presented.
- Header throughput is 1 byte/cycle. There are no bubbles between header and payload, or between back-to-back frames.
- Reset values: FSM = HEADER, counters = 0, hdr_* = 0, hdr_valid = drop = truncated = 0. axis_o_tvalid = 0 and axis_i_tready = 0 while areset is high.
- areset mid-packet aborts immediately. The remainder of the frame is then parsed as a new header and is expected to be dropped.
- The input may stall (tvalid low) at any byte; state holds.

## Configuration
- IP_HEADER_PARSER_CHECKSUM_EN
  - Defined: the checksum is accumulated and checked as above.
  - Undefined: no checksum logic; the checksum check always passes and the other checks are unchanged.

## Test plan
- Header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7 + 95 payload bytes, tlast on byte 115:
  - hdr_valid pulses once.
  - src = C0A80001, dest = C0A800C7, protocol = 11, payload_length = 95.
  - 95 bytes are output with tlast on the 95th; no drop.
- Same packet followed by 10 padding bytes (tlast on byte 125):
  - 95 bytes are output, tlast on the 95th.
  - Padding is consumed with axis_o_tvalid = 0; the next frame parses normally.
- Same packet with checksum B862:
  - Macro defined: drop pulses, zero output beats, hdr_* unchanged.
  - Macro undefined: accepted as in the first scenario.
- Byte 0 = 46, or flags 2000 (MF set): drop pulses and the whole frame is consumed.
- Valid header with total_length 0073 but tlast on byte 60: 40 payload bytes are output, tlast on the 40th, and truncated pulses.
- Random axis_o_tready (50%) and axis_i_tvalid gaps over 100 back-to-back packets: payload matches byte-for-byte, hdr_valid count = 100, and no beats are lost or duplicated.
